// File: rtl/jfpjc_rle_encoder.sv
// Baseline-JPEG run-length symbol encoder: DC prediction, ZRL insertion, EOB, output backpressure.
// Optional event counters (stat_symbols, stat_blocks) are built when JFPJC_RLE_STATS_EN is defined.
module jfpjc_rle_encoder #(
   parameter int unsigned COEFF_WIDTH = 16,
   parameter int unsigned AMP_WIDTH   = 12
) (
   input  logic                          clock,
   input  logic                          nreset,
   input  logic                          frame_start,
   input  logic signed [COEFF_WIDTH-1:0] in_coeff,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic        [3:0]             out_run,
   output logic        [3:0]             out_size,
   output logic        [AMP_WIDTH-1:0]   out_amplitude,
   output logic                          out_is_dc,
   output logic                          out_last
`ifdef JFPJC_RLE_STATS_EN
   ,
   output logic        [31:0]            stat_symbols,
   output logic        [15:0]            stat_blocks
`endif
);

   typedef enum logic [0:0] {StAccept, StZrl} state_e;

   localparam int AmpMaxInt = (1 << (AMP_WIDTH - 1)) - 1;
   localparam logic signed [COEFF_WIDTH-1:0] CoeffMax = COEFF_WIDTH'(AmpMaxInt);
   localparam logic signed [COEFF_WIDTH-1:0] CoeffMin = -CoeffMax;
   localparam logic signed [AMP_WIDTH-1:0]   AmpMax   = AMP_WIDTH'(AmpMaxInt);
   localparam logic signed [AMP_WIDTH:0]     DiffMax  = (AMP_WIDTH + 1)'(AmpMaxInt);
   localparam logic signed [AMP_WIDTH:0]     DiffMin  = -DiffMax;

   state_e                        state_q, state_d;
   logic [5:0]                    k_q, k_d, r_q, r_d;
   logic signed [AMP_WIDTH-1:0]   pred_q, pred_d, hold_v_q, hold_v_d;
   logic                          hold_last_q, hold_last_d;
   logic                          out_valid_q, out_valid_d, out_is_dc_q, out_is_dc_d;
   logic                          out_last_q, out_last_d;
   logic [3:0]                    out_run_q, out_run_d, out_size_q, out_size_d;
   logic [AMP_WIDTH-1:0]          out_amp_q, out_amp_d;

   logic signed [AMP_WIDTH-1:0]   v, diff, code_x;
   logic signed [AMP_WIDTH:0]     diff_wide;
   logic [3:0]                    code_size;
   logic [AMP_WIDTH-1:0]          code_amp;
   logic                          slot_free, accept;
   logic                          emit, em_coded, em_dc, em_last;
   logic [3:0]                    em_run;

   function automatic logic [3:0] coef_size(input logic signed [AMP_WIDTH-1:0] x);
      logic [AMP_WIDTH-1:0] mag;
      coef_size = '0;
      mag = x[AMP_WIDTH-1] ? (~x + 1'b1) : x;
      for (int i = 0; i < AMP_WIDTH; i++) begin
         if (mag[i]) coef_size = 4'(i + 1);
      end
   endfunction

   // Negative values are coded as (x-1) truncated to size bits (one's complement of |x|).
   function automatic logic [AMP_WIDTH-1:0] coef_amp(input logic signed [AMP_WIDTH-1:0] x,
                                                      input logic [3:0] size);
      logic [AMP_WIDTH-1:0] xm1;
      coef_amp = '0;
      xm1 = x - 1'b1;
      for (int i = 0; i < AMP_WIDTH; i++) begin
         if (i < int'(size)) coef_amp[i] = x[AMP_WIDTH-1] ? xm1[i] : x[i];
      end
   endfunction

   always_comb begin
      if (in_coeff > CoeffMax)      v = AmpMax;
      else if (in_coeff < CoeffMin) v = -AmpMax;
      else                          v = in_coeff[AMP_WIDTH-1:0];
      diff_wide = {v[AMP_WIDTH-1], v} - {pred_q[AMP_WIDTH-1], pred_q};
      if (diff_wide > DiffMax)      diff = AmpMax;
      else if (diff_wide < DiffMin) diff = -AmpMax;
      else                          diff = diff_wide[AMP_WIDTH-1:0];
      code_x    = (state_q == StZrl) ? hold_v_q : ((k_q == 6'd0) ? diff : v);
      code_size = coef_size(code_x);
      code_amp  = coef_amp(code_x, code_size);
   end

   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = nreset && (state_q == StAccept) && !frame_start && slot_free;
   assign accept    = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      r_d         = r_q;
      pred_d      = pred_q;
      hold_v_d    = hold_v_q;
      hold_last_d = hold_last_q;
      out_valid_d = out_valid_q && !out_ready;
      out_run_d   = out_run_q;
      out_size_d  = out_size_q;
      out_amp_d   = out_amp_q;
      out_is_dc_d = out_is_dc_q;
      out_last_d  = out_last_q;
      emit        = 1'b0;
      em_coded    = 1'b0;
      em_dc       = 1'b0;
      em_last     = 1'b0;
      em_run      = 4'd0;
      if (frame_start) begin
         state_d     = StAccept;
         k_d         = '0;
         r_d         = '0;
         pred_d      = '0;
         out_valid_d = 1'b0;
      end else if (accept) begin
         k_d = k_q + 6'd1;
         if (k_q == 6'd0) begin
            emit     = 1'b1;
            em_coded = 1'b1;
            em_dc    = 1'b1;
            pred_d   = v;
         end else if (v == '0) begin
            // Trailing zeros collapse into EOB; no ZRL is ever emitted for them.
            if (k_q == 6'd63) begin
               emit    = 1'b1;
               em_last = 1'b1;
               r_d     = '0;
            end else begin
               r_d = r_q + 6'd1;
            end
         end else if (r_q < 6'd16) begin
            emit     = 1'b1;
            em_coded = 1'b1;
            em_run   = r_q[3:0];
            em_last  = (k_q == 6'd63);
            r_d      = '0;
         end else begin
            hold_v_d    = v;
            hold_last_d = (k_q == 6'd63);
            state_d     = StZrl;
            emit        = 1'b1;
            em_run      = 4'd15;
         end
      end else if (state_q == StZrl && slot_free) begin
         emit = 1'b1;
         if (r_q >= 6'd32) begin
            em_run = 4'd15;
            r_d    = r_q - 6'd16;
         end else begin
            em_run   = 4'(r_q - 6'd16);
            em_coded = 1'b1;
            em_last  = hold_last_q;
            state_d  = StAccept;
            r_d      = '0;
         end
      end
      if (emit) begin
         out_valid_d = 1'b1;
         out_run_d   = em_run;
         out_size_d  = em_coded ? code_size : 4'd0;
         out_amp_d   = em_coded ? code_amp : '0;
         out_is_dc_d = em_dc;
         out_last_d  = em_last;
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q     <= StAccept;
         k_q         <= '0;
         r_q         <= '0;
         pred_q      <= '0;
         hold_v_q    <= '0;
         hold_last_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_run_q   <= '0;
         out_size_q  <= '0;
         out_amp_q   <= '0;
         out_is_dc_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         r_q         <= r_d;
         pred_q      <= pred_d;
         hold_v_q    <= hold_v_d;
         hold_last_q <= hold_last_d;
         out_valid_q <= out_valid_d;
         out_run_q   <= out_run_d;
         out_size_q  <= out_size_d;
         out_amp_q   <= out_amp_d;
         out_is_dc_q <= out_is_dc_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_run       = out_run_q;
   assign out_size      = out_size_q;
   assign out_amplitude = out_amp_q;
   assign out_is_dc     = out_is_dc_q;
   assign out_last      = out_last_q;

`ifdef JFPJC_RLE_STATS_EN
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         stat_symbols <= '0;
         stat_blocks  <= '0;
      end else if (frame_start) begin
         stat_symbols <= '0;
         stat_blocks  <= '0;
      end else if (out_valid_q && out_ready) begin
         stat_symbols <= stat_symbols + 32'd1;
         if (out_last_q) stat_blocks <= stat_blocks + 16'd1;
      end
   end
`endif

endmodule
